// File: rtl/nes_video_pkg.sv
// Shared definitions for the NES video path.
//   NES_PIX_W    : width of a palette-index pixel
//   pix_state_e  : states of the pixel FIFO controller
//   level_width  : width needed to count 0..depth entries
package nes_video_pkg;

  localparam int NES_PIX_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_PREFILL,
    ST_STREAM
  } pix_state_e;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pixel_fifo_ctrl_if.sv
// Bundle of every non-clock signal around the pixel FIFO controller:
// producer side (frame_start, pix_in*), consumer side (pix_req, pix_out*),
// the attached FIFO (fifo_*), and status (level, underflow, overflow).
//   master : environment (PPU, video out, FIFO macro) driving the controller
//   slave  : the controller itself
interface pixel_fifo_ctrl_if
  import nes_video_pkg::*;
#(
  parameter int DATA_W = NES_PIX_W,
  parameter int DEPTH  = 16
) ();

  localparam int LVL_W = level_width(DEPTH);

  logic              frame_start;
  logic              pix_in_valid;
  logic [DATA_W-1:0] pix_in;
  logic              pix_in_stall;
  logic              pix_req;
  logic [DATA_W-1:0] pix_out;
  logic              pix_out_valid;
  logic              fifo_we;
  logic              fifo_re;
  logic [DATA_W-1:0] fifo_din;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic [LVL_W-1:0]  level;
  logic              underflow;
  logic              overflow;

  modport master (
    output frame_start, pix_in_valid, pix_in, pix_req,
           fifo_dout, fifo_empty, fifo_full,
    input  pix_in_stall, pix_out, pix_out_valid,
           fifo_we, fifo_re, fifo_din, level, underflow, overflow
  );

  modport slave (
    input  frame_start, pix_in_valid, pix_in, pix_req,
           fifo_dout, fifo_empty, fifo_full,
    output pix_in_stall, pix_out, pix_out_valid,
           fifo_we, fifo_re, fifo_din, level, underflow, overflow
  );

endinterface

// File: rtl/fifo_level_counter.sv
// Occupancy counter for the pixel FIFO controller.
//   clk, reset_n : clock, async active-low reset
//   i_clr        : force the count to zero (end of flush)
//   i_inc/i_dec  : one write / one read this cycle; both together cancel
//   o_level      : current count
//   o_level_nxt  : count after this cycle's update (used for prefill exit)
// The controller never writes at DEPTH nor reads at zero, so the count
// stays in range without any saturation.
module fifo_level_counter
  import nes_video_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LVL_W = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [LVL_W-1:0] o_level,
  output logic [LVL_W-1:0] o_level_nxt
);

  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_nxt;

  always_comb begin
    w_level_nxt = r_level;
    if (i_clr)
      w_level_nxt = '0;
    else if (i_inc && !i_dec)
      w_level_nxt = r_level + LVL_W'(1);
    else if (i_dec && !i_inc)
      w_level_nxt = r_level - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_level <= '0;
    else          r_level <= w_level_nxt;
  end

  assign o_level     = r_level;
  assign o_level_nxt = w_level_nxt;

endmodule

// File: rtl/pixel_fifo_ctrl.sv
// Pixel FIFO controller between the PPU (producer) and video out (consumer).
// Each frame it drains the external FIFO (FLUSH), collects PREFILL pixels
// (PREFILL), then serves one pixel per consumer request (STREAM).
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : producer/consumer handshakes, FIFO enables/data/flags,
//                  occupancy level and sticky underflow/overflow flags
// The interface instance must carry the same DATA_W/DEPTH as this module.
module pixel_fifo_ctrl
  import nes_video_pkg::*;
#(
  parameter int DATA_W  = NES_PIX_W,
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  pixel_fifo_ctrl_if.slave bus
);

  localparam int LVL_W = level_width(DEPTH);

  if (PREFILL < 1 || PREFILL > DEPTH) begin : g_bad_prefill
    $error("PREFILL must lie in 1..DEPTH");
  end

  pix_state_e        r_state;
  pix_state_e        w_state_nxt;
  logic [LVL_W-1:0]  w_level;
  logic [LVL_W-1:0]  w_level_nxt;
  logic              w_stall;
  logic              w_we;
  logic              w_re;
  logic              w_stream_rd;
  logic              w_flush_done;
  logic              w_at_depth;
  logic              w_filling;
  logic              r_re_d;       // any FIFO read issued last cycle
  logic              r_out_pend;   // STREAM read issued last cycle
  logic [DATA_W-1:0] r_pix_hold;
  logic              r_underflow;
  logic              r_overflow;

  assign w_at_depth   = (w_level == LVL_W'(DEPTH));
  assign w_filling    = (r_state == ST_PREFILL) || (r_state == ST_STREAM);
  // Leave FLUSH only once the FIFO is empty and the last read has landed.
  assign w_flush_done = (r_state == ST_FLUSH) && bus.fifo_empty && !r_re_d;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  // NOTE: the default assignment first keeps this purely combinational;
  // any path leaving w_state_nxt unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    w_state_nxt = ST_IDLE;
      ST_FLUSH:   if (w_flush_done) w_state_nxt = ST_PREFILL;
      ST_PREFILL: if (w_level_nxt >= LVL_W'(PREFILL)) w_state_nxt = ST_STREAM;
      ST_STREAM:  w_state_nxt = ST_STREAM;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (bus.frame_start) w_state_nxt = ST_FLUSH;
  end

  // Output logic. Stall is judged on the pre-cycle level, so a read at
  // DEPTH does not open a write slot in the same cycle.
  always_comb begin
    w_stall     = 1'b1;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_stream_rd = 1'b0;
    unique case (r_state)
      ST_FLUSH: w_re = !bus.fifo_empty;
      ST_PREFILL: begin
        w_stall = w_at_depth || bus.fifo_full;
        w_we    = bus.pix_in_valid && !w_stall;
      end
      ST_STREAM: begin
        w_stall     = w_at_depth || bus.fifo_full;
        w_we        = bus.pix_in_valid && !w_stall;
        w_stream_rd = bus.pix_req && (w_level != '0) && !bus.fifo_empty;
        w_re        = w_stream_rd;
      end
      default: ;
    endcase
  end

  fifo_level_counter #(.DEPTH(DEPTH)) u_level (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clr       (w_flush_done),
    .i_inc       (w_we),
    .i_dec       (w_stream_rd),
    .o_level     (w_level),
    .o_level_nxt (w_level_nxt)
  );

  // Read tracking and pixel hold register.
  // NOTE: the data hold register is reset as well, since pix_out must read
  // zero while reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_re_d     <= 1'b0;
      r_out_pend <= 1'b0;
      r_pix_hold <= '0;
    end else begin
      r_re_d     <= w_re;
      r_out_pend <= w_stream_rd;
      if (r_out_pend) r_pix_hold <= bus.fifo_dout;
    end
  end

  // Sticky error flags; a new frame clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (bus.frame_start) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if ((r_state == ST_STREAM) && bus.pix_req && (w_level == '0))
        r_underflow <= 1'b1;
      if (w_filling && bus.pix_in_valid && w_stall && w_at_depth)
        r_overflow <= 1'b1;
    end
  end

  // FIFO data is valid the cycle after the read; present it directly then,
  // and hold the captured copy afterwards.
  assign bus.pix_out       = r_out_pend ? bus.fifo_dout : r_pix_hold;
  assign bus.pix_out_valid = r_out_pend;
  assign bus.pix_in_stall  = w_stall;
  assign bus.fifo_we       = w_we;
  assign bus.fifo_re       = w_re;
  assign bus.fifo_din      = bus.pix_in;
  assign bus.level         = w_level;
  assign bus.underflow     = r_underflow;
  assign bus.overflow      = r_overflow;

endmodule

// File: tb/tb_pixel_fifo_ctrl.sv
// Self-checking bench for pixel_fifo_ctrl: a behavioural 16-entry FIFO
// model, a scoreboard queue filled when pixels are offered and drained when
// pix_out_valid appears, plus directed checks of flags, stall and level.
module tb_pixel_fifo_ctrl;

  localparam int DW    = 6;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  pixel_fifo_ctrl_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  pixel_fifo_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .PREFILL(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural FIFO: read data appears the cycle after fifo_re.
  logic [DW-1:0] mem [DEPTH];
  logic [3:0]    m_wp = '0;
  logic [3:0]    m_rp = '0;
  int            m_cnt = 0;
  logic [DW-1:0] m_dout = '0;

  always @(posedge clk) begin
    if (bus.fifo_we && m_cnt < DEPTH) begin
      mem[m_wp] <= bus.fifo_din;
      m_wp      <= m_wp + 4'd1;
    end
    if (bus.fifo_re && m_cnt > 0) begin
      m_dout <= mem[m_rp];
      m_rp   <= m_rp + 4'd1;
    end
    m_cnt <= m_cnt + ((bus.fifo_we && m_cnt < DEPTH) ? 1 : 0)
                   - ((bus.fifo_re && m_cnt > 0) ? 1 : 0);
  end

  assign bus.fifo_dout  = m_dout;
  assign bus.fifo_empty = (m_cnt == 0);
  assign bus.fifo_full  = (m_cnt == DEPTH);

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_level",     32'(bus.level), 0);
    check("rst_we",        32'(bus.fifo_we), 0);
    check("rst_re",        32'(bus.fifo_re), 0);
    check("rst_pix_out",   32'(bus.pix_out), 0);
    check("rst_out_valid", 32'(bus.pix_out_valid), 0);
    check("rst_underflow", 32'(bus.underflow), 0);
    check("rst_overflow",  32'(bus.overflow), 0);
    check("rst_stall",     32'(bus.pix_in_stall), 1);
  endtask

  // Wait (bounded) for the controller to leave FLUSH; returns reads seen.
  task automatic wait_flush(output int n_rd, output bit done);
    n_rd = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (!bus.pix_in_stall) done = 1'b1;
      else begin
        if (bus.fifo_re) n_rd++;
        tick();
        #1;
      end
    end
  endtask

  // Output monitor: protocol rules and scoreboard comparison.
  always @(negedge clk) begin
    if (reset_n) begin
      check("we_while_full",  32'(bus.fifo_we & bus.fifo_full), 0);
      check("re_while_empty", 32'(bus.fifo_re & bus.fifo_empty), 0);
      if (bus.pix_out_valid) begin
        check("out_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) check("pix_out", 32'(bus.pix_out), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] pix8 [8] = '{6'h20, 6'h02, 6'h15, 6'h3F, 6'h00, 6'h2A, 6'h11, 6'h07};

  initial begin
    int  n_rd;
    bit  done;

    reset_n          = 1'b0;
    bus.frame_start  = 1'b0;
    bus.pix_in_valid = 1'b0;
    bus.pix_in       = '0;
    bus.pix_req      = 1'b0;
    repeat (3) tick();
    check_reset_values();

    // IDLE ignores both sides until frame_start.
    reset_n          = 1'b1;
    bus.pix_req      = 1'b1;
    bus.pix_in_valid = 1'b1;
    bus.pix_in       = 6'h15;
    repeat (3) tick();
    #1;
    check("idle_stall", 32'(bus.pix_in_stall), 1);
    check("idle_re",    32'(bus.fifo_re), 0);
    check("idle_we",    32'(bus.fifo_we), 0);

    // frame_start with empty FIFO: one FLUSH cycle, then PREFILL.
    bus.frame_start  = 1'b1;
    bus.pix_in_valid = 1'b0;
    bus.pix_req      = 1'b0;
    tick();
    bus.frame_start = 1'b0;
    #1;
    check("flush_stall",    32'(bus.pix_in_stall), 1);
    check("flush_re_empty", 32'(bus.fifo_re), 0);
    check("idle_overflow",  32'(bus.overflow), 0);
    tick();
    #1;
    check("prefill_stall", 32'(bus.pix_in_stall), 0);
    check("prefill_level", 32'(bus.level), 0);

    // Prefill 8 pixels while the consumer already requests.
    bus.pix_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.pix_in_valid = 1'b1;
      bus.pix_in       = pix8[i];
      sb.push_back(pix8[i]);
      #1;
      check("prefill_we", 32'(bus.fifo_we), 1);
      check("prefill_re", 32'(bus.fifo_re), 0);
      tick();
    end
    bus.pix_in_valid = 1'b0;
    #1;
    check("stream_level8", 32'(bus.level), 8);
    check("stream_re",     32'(bus.fifo_re), 1);
    check("no_underflow",  32'(bus.underflow), 0);
    repeat (7) tick();
    #1;
    check("level_one",    32'(bus.level), 1);
    check("re_level_one", 32'(bus.fifo_re), 1);
    tick();
    #1;
    check("level_zero",     32'(bus.level), 0);
    check("re_level_zero",  32'(bus.fifo_re), 0);
    check("underflow_late", 32'(bus.underflow), 0);
    tick();
    bus.pix_req = 1'b0;
    #1;
    check("underflow_set",   32'(bus.underflow), 1);
    check("out_valid_idle",  32'(bus.pix_out_valid), 0);
    check("pix_out_hold",    32'(bus.pix_out), 32'h07);
    check("sb_drained",      32'(sb.size()), 0);

    // Fill to DEPTH with no requests; producer ignores the stall.
    for (int i = 0; i < DEPTH; i++) begin
      bus.pix_in_valid = 1'b1;
      bus.pix_in       = DW'((i * 5 + 3) & 63);
      sb.push_back(DW'((i * 5 + 3) & 63));
      #1;
      check("fill_we", 32'(bus.fifo_we), 1);
      tick();
    end
    #1;
    check("full_level", 32'(bus.level), 16);
    check("full_stall", 32'(bus.pix_in_stall), 1);
    check("full_we",    32'(bus.fifo_we), 0);
    tick();
    #1;
    check("overflow_set", 32'(bus.overflow), 1);
    bus.pix_req = 1'b1;
    #1;
    check("full_rd_re",    32'(bus.fifo_re), 1);
    check("full_rd_stall", 32'(bus.pix_in_stall), 1);
    check("full_rd_we",    32'(bus.fifo_we), 0);
    tick();
    bus.pix_in_valid = 1'b0;
    repeat (10) tick();
    bus.pix_req = 1'b0;
    #1;
    check("level_five", 32'(bus.level), 5);
    tick();
    check("sb_left_five", 32'(sb.size()), 5);
    sb.delete();

    // New frame with 5 pixels still stored: all drained, none presented.
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    #1;
    check("ff_underflow_clr", 32'(bus.underflow), 0);
    check("ff_overflow_clr",  32'(bus.overflow), 0);
    check("ff_stall",         32'(bus.pix_in_stall), 1);
    wait_flush(n_rd, done);
    check("flush5_done",  32'(done), 1);
    check("flush5_reads", 32'(n_rd), 5);
    check("flush5_level", 32'(bus.level), 0);

    // Reset in the middle of streaming.
    for (int i = 0; i < 8; i++) begin
      bus.pix_in_valid = 1'b1;
      bus.pix_in       = DW'(6'h30 + i);
      sb.push_back(DW'(6'h30 + i));
      tick();
    end
    bus.pix_in_valid = 1'b0;
    bus.pix_req      = 1'b1;
    tick();
    tick();
    bus.pix_in_valid = 1'b1;
    #1;
    check("pre_rst_valid", 32'(bus.pix_out_valid), 1);
    reset_n = 1'b0;
    #1;
    check_reset_values();
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    #1;
    check("post_rst_stall", 32'(bus.pix_in_stall), 1);
    check("post_rst_re",    32'(bus.fifo_re), 0);
    check("post_rst_we",    32'(bus.fifo_we), 0);
    check("post_rst_level", 32'(bus.level), 0);
    bus.pix_in_valid = 1'b0;
    bus.pix_req      = 1'b0;
    bus.frame_start  = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    #1;
    wait_flush(n_rd, done);
    check("post_rst_flush_done",  32'(done), 1);
    check("post_rst_flush_reads", 32'(n_rd), 6);
    check("post_rst_flush_level", 32'(bus.level), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_fifo_ctrl.md
PIXEL_FIFO_CTRL -- requirements
Module: pixel_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 6, pixel width (NES palette index).
REQ-002 Parameter DEPTH, default 16, attached FIFO depth in entries.
REQ-003 Parameter PREFILL, default 8, level needed before streaming starts; legal range 1..DEPTH.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 frame_start  in  1  one-cycle pulse that starts a new frame.
REQ-007 pix_in_valid  in  1  producer (PPU) offers pix_in this cycle.
REQ-008 pix_in  in  DATA_W  producer pixel.
REQ-009 pix_in_stall  out  1  producer must hold pix_in; pixel not accepted.
REQ-010 pix_req  in  1  consumer (video out) requests one pixel.
REQ-011 pix_out  out  DATA_W  pixel to consumer.
REQ-012 pix_out_valid  out  1  pix_out holds a fresh pixel this cycle.
REQ-013 fifo_we, fifo_re  out  1 each  FIFO write/read enables.
REQ-014 fifo_din  out  DATA_W  FIFO write data; equals pix_in.
REQ-015 fifo_dout  in  DATA_W  FIFO read data, valid one cycle after fifo_re.
REQ-016 fifo_empty, fifo_full  in  1 each  FIFO status flags.
REQ-017 level  out  clog2(DEPTH+1)  controller occupancy count.
REQ-018 underflow, overflow  out  1 each  sticky error flags.

Function
REQ-019 States: IDLE, FLUSH, PREFILL, STREAM.
REQ-020 frame_start in any state -> FLUSH next cycle, clearing underflow and overflow.
REQ-021 IDLE: no FIFO access; pix_in_stall=1; leave only on frame_start.
REQ-022 FLUSH: fifo_re=1 each cycle fifo_empty=0; read data discarded; pix_in_stall=1; -> PREFILL the cycle after fifo_empty=1 with no read in flight.
REQ-023 PREFILL: writes only; pix_req ignored, pix_out_valid=0; -> STREAM when level >= PREFILL (after the update of that cycle).
REQ-024 STREAM: fifo_re = pix_req & (level != 0); pix_out_valid=1 exactly one cycle after each fifo_re, pix_out = fifo_dout captured then.
REQ-025 pix_out holds its last value while pix_out_valid=0.
REQ-026 fifo_we = pix_in_valid & ~pix_in_stall, only in PREFILL/STREAM.
REQ-027 pix_in_stall = 1 in IDLE/FLUSH, or when level==DEPTH, or fifo_full=1, judged on pre-cycle level; simultaneous read at full does not release stall that cycle.
REQ-028 level: +1 on write only, -1 on read only, unchanged on both or neither; saturating arithmetic is forbidden (must never need it); level reset to 0 on FLUSH exit.
REQ-029 underflow sets when pix_req=1 in STREAM with level==0.
REQ-030 overflow sets when pix_in_valid=1 while pix_in_stall=1 in PREFILL/STREAM and level==DEPTH (producer ignored stall).
REQ-031 fifo_we and fifo_re never asserted when fifo_full resp. fifo_empty is 1.

Reset
REQ-032 reset_n=0 asynchronously forces: state IDLE, level 0, fifo_we 0, fifo_re 0, pix_out 0, pix_out_valid 0, underflow 0, overflow 0, pix_in_stall 1.
REQ-033 Reset asserted mid-frame abandons in-flight read; first action after release is waiting for frame_start.

Structure
REQ-034 State enum and DATA_W default live in shared package nes_video_pkg.
REQ-035 Single module; occupancy counter may be sub-module fifo_level_counter.

Verification
REQ-036 Reset then frame_start, FIFO empty -> FLUSH 1 cycle, PREFILL; stall=1 in IDLE/FLUSH.
REQ-037 Write 0x20,0x02,...8 pixels with pix_req=1 throughout -> no reads until level=8, then STREAM; pix_out sequence 0x20,0x02,... each one cycle after fifo_re.
REQ-038 Continuous write 16 pixels, no pix_req -> level=16, pix_in_stall=1, fifo_we=0 at 17th; overflow=1 if pix_in_valid kept.
REQ-039 STREAM, level=1, pix_req two cycles -> one pixel out, underflow=1 second cycle, pix_out holds.
REQ-040 frame_start with level=5 -> FLUSH issues 5 reads, outputs no pixel_valid, flags cleared, PREFILL.
REQ-041 reset_n low mid-STREAM -> all outputs at reset values same cycle, stays IDLE until frame_start.
